// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Loader state codes and byte-packing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_DONE   = 3'd4,
        LD_ERROR  = 3'd5
    } ld_state_t;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam logic [1:0]  LAST_BYTE = 2'd3;

    function automatic logic [WORD_W-1:0] byte_addr(input logic [WORD_W-1:0] word_idx);
        return word_idx << 2;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid flags the
// cycle in which the fourth byte of a word is being shifted in.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [WORD_W-BYTE_W-1:0] shift;
    logic [1:0]               byte_cnt;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            shift    <= {shift[WORD_W-2*BYTE_W-1:0], in_byte};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Completed word is exposed combinationally so the writer can register it on the same edge.
    assign word       = {shift, in_byte};
    assign word_valid = shift_en && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: receives a length-prefixed byte image,
// writes it word by word from address 0 and holds the core in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned WORDS_MAX = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;

    ld_state_t        state, state_next;
    logic [15:0]      len;
    logic [15:0]      len_in;
    logic [CNT_W-1:0] word_cnt;
    logic             accept;
    logic             all_written;
    logic             restart;
    logic             clear;
    logic             shift_en;
    logic             word_valid;
    logic [31:0]      word;

    assign in_ready    = (state == LD_LEN_HI) || (state == LD_LEN_LO) || (state == LD_DATA);
    assign accept      = in_valid && in_ready;
    assign len_in      = {len[15:8], in_byte};
    assign all_written = (32'(word_cnt) == 32'(len));
    assign restart     = start && ((state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERROR));
    assign clear       = accept && (state == LD_LEN_LO);
    // Bytes arriving during the final write pulse must not open a further word.
    assign shift_en    = accept && (state == LD_DATA) && !all_written;

    assign done       = (state == LD_DONE);
    assign error      = (state == LD_ERROR);
    assign core_reset = (state != LD_DONE);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .shift_en   (shift_en),
        .in_byte    (in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) state_next = LD_LEN_HI;
            end
            LD_LEN_HI: begin
                if (accept) state_next = LD_LEN_LO;
            end
            LD_LEN_LO: begin
                if (accept) begin
                    if (len_in == 16'd0)                  state_next = LD_DONE;
                    else if (32'(len_in) > WORDS_MAX)     state_next = LD_ERROR;
                    else                                  state_next = LD_DATA;
                end
            end
            LD_DATA: begin
                // Leave only once the last word's write pulse is on the port.
                if (mem_we && all_written) state_next = LD_DONE;
            end
            default: state_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len       <= '0;
            word_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept && (state == LD_LEN_HI)) len[15:8] <= in_byte;
            if (clear) begin
                len[7:0] <= in_byte;
                word_cnt <= '0;
            end
            if (restart) word_cnt <= '0;
            if (word_valid) begin
                mem_we    <= 1'b1;
                mem_wdata <= word;
                mem_addr  <= byte_addr(32'(word_cnt[ADDR_WIDTH-1:0]));
                word_cnt  <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, normal loads, empty and oversize
// images, gapped stream with stray start, reset mid-load and a full-memory load.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  s5 [10];

    always #5 clock = ~clock;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always @(posedge clock) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic gap(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int n = 0; n < 100; n++) begin
            rdy = in_ready;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_accept_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        s5 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'hA5;

        // 1: reset held three cycles with a byte offered
        repeat (3) tick();
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        check("rst_mem_addr",   mem_addr,        32'h0);
        check("rst_writes",     32'(wr_addr_q.size()), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b1;
        tick();
        check("idle_no_accept", 32'(in_ready), 32'd0);

        // 2: two-word image
        in_valid = 1'b0;
        pulse_start();
        check("t2_ready_len_hi", 32'(in_ready), 32'd1);
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        check("t2_w0_we",   32'(mem_we), 32'd1);
        check("t2_w0_addr", mem_addr,    32'h0000_0000);
        check("t2_w0_data", mem_wdata,   32'h2008_0005);
        send(8'h01); send(8'h09); send(8'h50); send(8'h20);
        check("t2_w1_we",   32'(mem_we), 32'd1);
        check("t2_w1_addr", mem_addr,    32'h0000_0004);
        check("t2_w1_data", mem_wdata,   32'h0109_5020);
        check("t2_done_not_yet", 32'(done), 32'd0);
        tick();
        check("t2_done",       32'(done),       32'd1);
        check("t2_core_reset", 32'(core_reset), 32'd0);
        check("t2_we_low",     32'(mem_we),     32'd0);
        check("t2_ready_low",  32'(in_ready),   32'd0);
        repeat (3) tick();
        check("t2_addr_hold",  mem_addr,        32'h0000_0004);
        check("t2_writes",     32'(wr_addr_q.size()), 32'd2);

        // 3: empty image
        pulse_start();
        check("t3_done_cleared", 32'(done),       32'd0);
        check("t3_core_reset",   32'(core_reset), 32'd1);
        send(8'h00); send(8'h00);
        check("t3_done",       32'(done),       32'd1);
        check("t3_core_rel",   32'(core_reset), 32'd0);
        repeat (2) tick();
        check("t3_writes",     32'(wr_addr_q.size()), 32'd2);

        // 4: oversize image (257 words)
        pulse_start();
        send(8'h01); send(8'h01);
        check("t4_error",      32'(error),      32'd1);
        check("t4_in_ready",   32'(in_ready),   32'd0);
        check("t4_core_reset", 32'(core_reset), 32'd1);
        check("t4_done",       32'(done),       32'd0);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        repeat (4) tick();
        in_valid = 1'b0;
        check("t4_writes",     32'(wr_addr_q.size()), 32'd2);
        pulse_start();
        check("t4_error_clr",  32'(error),    32'd0);
        check("t4_ready_again", 32'(in_ready), 32'd1);

        // 5: same image as test 2 with random gaps and a stray start mid-word
        for (int i = 0; i < 10; i++) begin
            gap($urandom_range(0, 5));
            if (i == 5) begin
                pulse_start();
                check("t5_start_ignored_ready", 32'(in_ready), 32'd1);
                check("t5_start_ignored_done",  32'(done),     32'd0);
            end
            send(s5[i]);
        end
        check("t5_last_we", 32'(mem_we), 32'd1);
        tick();
        check("t5_done",    32'(done), 32'd1);
        check("t5_writes",  32'(wr_addr_q.size()), 32'd4);
        check("t5_w0_addr", wr_addr_q[2], 32'h0000_0000);
        check("t5_w0_data", wr_data_q[2], 32'h2008_0005);
        check("t5_w1_addr", wr_addr_q[3], 32'h0000_0004);
        check("t5_w1_data", wr_data_q[3], 32'h0109_5020);

        // 6: reset in the middle of the second word
        pulse_start();
        send(8'h00); send(8'h02);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        check("t6_w0_addr", mem_addr,  32'h0000_0000);
        check("t6_w0_data", mem_wdata, 32'hDEAD_BEEF);
        send(8'h11); send(8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_ready", 32'(in_ready),   32'd0);
        check("t6_rst_core",  32'(core_reset), 32'd1);
        check("t6_rst_done",  32'(done),       32'd0);
        check("t6_rst_data",  mem_wdata,       32'h0);
        repeat (3) tick();
        check("t6_writes",    32'(wr_addr_q.size()), 32'd5);
        pulse_start();
        send(8'h00); send(8'h01);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        check("t6_reload_addr", mem_addr,  32'h0000_0000);
        check("t6_reload_data", mem_wdata, 32'hAABB_CCDD);
        tick();
        check("t6_reload_done", 32'(done), 32'd1);
        check("t6_reload_writes", 32'(wr_addr_q.size()), 32'd6);

        // 7: exactly WORDS_MAX words fills memory without wrapping
        pulse_start();
        send(8'h01); send(8'h00);
        check("t7_no_error", 32'(error), 32'd0);
        for (int i = 0; i < 256; i++) begin
            send(8'(i)); send(8'hC3); send(8'(255 - i)); send(8'h5A);
        end
        check("t7_last_addr", mem_addr,  32'h0000_03FC);
        check("t7_last_data", mem_wdata, 32'hFFC3_005A);
        tick();
        check("t7_done",      32'(done), 32'd1);
        check("t7_writes",    32'(wr_addr_q.size()), 32'd262);
        check("t7_first_addr", wr_addr_q[6], 32'h0000_0000);
        check("t7_first_data", wr_data_q[6], 32'h00C3_FF5A);
        check("t7_mid_addr",   wr_addr_q[6 + 128], 32'h0000_0200);
        check("t7_mid_data",   wr_data_q[6 + 128], 32'h80C3_7F5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
